// File: rtl/alux_seq.sv
// Sequential MSP430X ALU (.B/.W/.A), repeated shifts and nibble-serial DADD; done = 1 + iterations cycles after the start cycle.
// No backpressure: start is taken only in IDLE, and result/flags hold until the next accepted start.
module alux_seq #(
    parameter int ADDR_W      = 20,
    parameter int MAX_RPT     = 16,
    parameter int NIB_PER_CYC = 1
) (
    input  logic                       MCLK,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [3:0]                 op,
    input  logic [1:0]                 size,
    input  logic [$clog2(MAX_RPT)-1:0] rpt,
    input  logic [ADDR_W-1:0]          src,
    input  logic [ADDR_W-1:0]          dst,
    input  logic                       Cin,
    input  logic                       Vin,
    input  logic                       Nin,
    input  logic                       Zin,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          result,
    output logic                       Cout,
    output logic                       Vout,
    output logic                       Nout,
    output logic                       Zout
);
    localparam int RPT_W  = $clog2(MAX_RPT);
    localparam int NIBS_A = (ADDR_W + 3) / 4;
    localparam int PW     = 4 * NIBS_A;
    localparam int NI_W   = $clog2(NIBS_A + NIB_PER_CYC + 1);
    localparam int CNT_W  = (RPT_W > NI_W) ? RPT_W : NI_W;
    localparam logic [31:0] DEAD = 32'hDEAD;

    typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;
    state_t state, nstate;

    logic [3:0]        op_q;
    logic [1:0]        sz_q;
    logic [CNT_W-1:0]  cnt_q, nxt_cnt;
    logic [ADDR_W-1:0] d_q, s_q;
    logic [PW-1:0]     w_q, nxt_w, dp, sp;
    logic              c_q, nxt_c, cin_q, vin_q, nin_q, zin_q;

    logic [ADDR_W-1:0] mask, top, dm, sm, b_op, res, wcur, shifted;
    logic [ADDR_W:0]   sum;
    logic              ci, last, calc_nz, cc, sh_in;
    logic              f_c, f_v, f_n, f_z;
    logic [5:0]        t;
    int                p, nibs;

    function automatic logic [ADDR_W-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return ADDR_W'(8'hFF);
            2'b01:   return ADDR_W'(16'hFFFF);
            default: return '1;
        endcase
    endfunction

    function automatic logic msb_of(input logic [ADDR_W-1:0] x, input logic [ADDR_W-1:0] tb);
        return |(x & tb);
    endfunction

    always_ff @(posedge MCLK) begin
        if (!reset_n) state <= IDLE;
        else          state <= nstate;
    end

    always_comb begin
        mask    = size_mask(sz_q);
        top     = mask & ~(mask >> 1);
        dm      = d_q & mask;
        sm      = s_q & mask;
        dp      = PW'(dm);
        sp      = PW'(sm);
        wcur    = w_q[ADDR_W-1:0];
        nibs    = (sz_q == 2'b00) ? 2 : (sz_q == 2'b01) ? 4 : NIBS_A;
        b_op    = sm;
        ci      = 1'b0;
        case (op_q)
            4'h2: ci = cin_q;
            4'h3, 4'h5: begin b_op = ~s_q & mask; ci = 1'b1; end
            4'h4: begin b_op = ~s_q & mask; ci = cin_q; end
            default: ;
        endcase
        sum     = {1'b0, dm} + {1'b0, b_op} + {{ADDR_W{1'b0}}, ci};
        nxt_w   = w_q;
        nxt_c   = c_q;
        nxt_cnt = cnt_q;
        last    = 1'b1;
        calc_nz = 1'b0;
        cc      = c_q;
        t       = '0;
        p       = 0;
        sh_in   = 1'b0;
        shifted = '0;
        res     = '0;
        f_c     = cin_q;
        f_v     = vin_q;
        f_n     = nin_q;
        f_z     = zin_q;
        if (sz_q == 2'b11) begin
            res = DEAD[ADDR_W-1:0];
            f_c = 1'b0; f_v = 1'b0; f_n = 1'b0; f_z = 1'b0;
        end else begin
            case (op_q)
                4'h0: res = sm;
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                    res     = sum[ADDR_W-1:0] & mask;
                    f_c     = |(sum & {top, 1'b0});
                    f_v     = (msb_of(dm, top) == msb_of(b_op, top)) && (msb_of(res, top) != msb_of(dm, top));
                    calc_nz = 1'b1;
                end
                4'h6: begin
                    // BCD carry lives in c_q between cycles, one digit slice per pass
                    for (int k = 0; k < NIB_PER_CYC; k++) begin
                        p = int'(cnt_q) + k;
                        if (p < nibs) begin
                            t = 6'(dp[4*p +: 4]) + 6'(sp[4*p +: 4]) + 6'(cc);
                            if (t > 6'd9) begin
                                t  = t + 6'd6;
                                cc = 1'b1;
                            end else begin
                                cc = 1'b0;
                            end
                            nxt_w[4*p +: 4] = t[3:0];
                        end
                    end
                    nxt_c   = cc;
                    nxt_cnt = cnt_q + CNT_W'(NIB_PER_CYC);
                    last    = (int'(cnt_q) + NIB_PER_CYC >= nibs);
                    res     = nxt_w[ADDR_W-1:0] & mask;
                    f_c     = cc;
                    f_v     = 1'b0;
                    calc_nz = 1'b1;
                end
                4'h7, 4'hB: begin
                    res = dm & sm; f_c = |res; f_v = 1'b0; calc_nz = 1'b1;
                end
                4'hA: begin
                    res = dm ^ sm; f_c = |res; f_v = msb_of(dm, top) & msb_of(sm, top); calc_nz = 1'b1;
                end
                4'h8: res = dm & ~sm;
                4'h9: res = dm | sm;
                default: begin
                    sh_in = (op_q == 4'hC) ? c_q : (op_q == 4'hD) ? msb_of(wcur, top) : 1'b0;
                    if (op_q == 4'hE) begin
                        shifted = (wcur << 1) & mask;
                        nxt_c   = msb_of(wcur, top);
                        f_v     = msb_of(wcur, top) ^ msb_of(shifted, top);
                    end else begin
                        shifted = (wcur >> 1) | (sh_in ? top : '0);
                        nxt_c   = wcur[0];
                        f_v     = 1'b0;
                    end
                    nxt_w   = PW'(shifted);
                    nxt_cnt = cnt_q - CNT_W'(1);
                    last    = (cnt_q == '0);
                    res     = shifted;
                    f_c     = nxt_c;
                    calc_nz = 1'b1;
                end
            endcase
        end
        if (calc_nz) begin
            f_n = msb_of(res, top);
            f_z = (res == '0);
        end

        nstate = state;
        case (state)
            IDLE:    if (start) nstate = EXEC;
            EXEC:    if (last) nstate = FIN;
            default: nstate = IDLE;
        endcase
        busy = (state != IDLE);
        done = (state == FIN);
    end

    always_ff @(posedge MCLK) begin
        if (!reset_n) begin
            op_q <= '0; sz_q <= '0; cnt_q <= '0; d_q <= '0; s_q <= '0; w_q <= '0;
            c_q <= 1'b0; cin_q <= 1'b0; vin_q <= 1'b0; nin_q <= 1'b0; zin_q <= 1'b0;
            result <= '0; Cout <= 1'b0; Vout <= 1'b0; Nout <= 1'b0; Zout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    sz_q  <= size;
                    d_q   <= dst;
                    s_q   <= src;
                    c_q   <= Cin;
                    cin_q <= Cin;
                    vin_q <= Vin;
                    nin_q <= Nin;
                    zin_q <= Zin;
                    cnt_q <= (op >= 4'hC) ? CNT_W'(rpt) : '0;
                    w_q   <= (op >= 4'hC) ? PW'(dst & size_mask(size)) : '0;
                end
                EXEC: begin
                    w_q   <= nxt_w;
                    c_q   <= nxt_c;
                    cnt_q <= nxt_cnt;
                    if (last) begin
                        result <= res;
                        Cout   <= f_c;
                        Vout   <= f_v;
                        Nout   <= f_n;
                        Zout   <= f_z;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alux_seq.sv
// Randomized bench for alux_seq against an arithmetic reference model, plus directed corner cases.
module tb_alux_seq;
    localparam int AW  = 20;
    localparam int NPC = 1;

    logic          MCLK, reset_n, start;
    logic [3:0]    op;
    logic [1:0]    size;
    logic [3:0]    rpt;
    logic [AW-1:0] src, dst, result;
    logic          Cin, Vin, Nin, Zin, busy, done, Cout, Vout, Nout, Zout;

    int n_cmp = 0;
    int n_err = 0;

    alux_seq #(.ADDR_W(AW), .MAX_RPT(16), .NIB_PER_CYC(NPC)) dut (
        .MCLK(MCLK), .reset_n(reset_n), .start(start), .op(op), .size(size), .rpt(rpt),
        .src(src), .dst(dst), .Cin(Cin), .Vin(Vin), .Nin(Nin), .Zin(Zin),
        .busy(busy), .done(done), .result(result),
        .Cout(Cout), .Vout(Vout), .Nout(Nout), .Zout(Zout)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    typedef struct {
        longint res;
        bit     c, v, n, z;
        int     lat;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int opx, input int sz, input int rp,
                                   input longint s_in, input longint d_in, input logic [3:0] fl);
        exp_t   e;
        int     w, cin_e, nb;
        longint m, d, s, r, b, full, sd, sb, tot, dg, cy, old, outb;
        e.c = fl[3]; e.v = fl[2]; e.n = fl[1]; e.z = fl[0]; e.lat = 2; e.res = 0;
        if (sz == 3) begin
            e.res = 64'hDEAD & ((64'd1 << AW) - 1);
            e.c = 0; e.v = 0; e.n = 0; e.z = 0;
            return e;
        end
        w = (sz == 0) ? 8 : (sz == 1) ? 16 : AW;
        m = (64'd1 << w) - 1;
        d = d_in & m;
        s = s_in & m;
        r = 0;
        case (opx)
            0: r = s;
            1, 2, 3, 4, 5: begin
                b     = (opx <= 2) ? s : (~s) & m;
                cin_e = (opx == 1) ? 0 : (opx == 2 || opx == 4) ? int'(fl[3]) : 1;
                full  = d + b + cin_e;
                r     = full & m;
                e.c   = ((full >> w) & 1) != 0;
                sd    = ((d >> (w - 1)) & 1) != 0 ? d - (m + 1) : d;
                sb    = ((b >> (w - 1)) & 1) != 0 ? b - (m + 1) : b;
                tot   = sd + sb + cin_e;
                e.v   = (tot > (m >> 1)) || (tot < -((m + 1) >> 1));
            end
            6: begin
                nb = (w + 3) / 4;
                cy = fl[3];
                for (int i = 0; i < nb; i++) begin
                    dg = ((d >> (4 * i)) & 15) + ((s >> (4 * i)) & 15) + cy;
                    if (dg > 9) begin dg = dg + 6; cy = 1; end
                    else cy = 0;
                    r = r | ((dg & 15) << (4 * i));
                end
                e.c   = (cy != 0);
                e.v   = 0;
                e.lat = 1 + (nb + NPC - 1) / NPC;
            end
            7, 11: begin r = d & s; e.v = 0; e.c = (r != 0); end
            10: begin
                r   = d ^ s;
                e.v = (((d & s) >> (w - 1)) & 1) != 0;
                e.c = (r != 0);
            end
            8: r = d & ~s & m;
            9: r = d | s;
            default: begin
                r = d;
                e.v = 0;
                for (int i = 0; i <= rp; i++) begin
                    old = r;
                    if (opx == 14) begin
                        outb = (r >> (w - 1)) & 1;
                        r    = (r << 1) & m;
                        e.v  = (((old ^ r) >> (w - 1)) & 1) != 0;
                    end else begin
                        outb = r & 1;
                        if (opx == 12)      r = (r >> 1) | (longint'(e.c) << (w - 1));
                        else if (opx == 13) r = (r >> 1) | (r & (64'd1 << (w - 1)));
                        else                r = r >> 1;
                    end
                    e.c = (outb != 0);
                end
                e.lat = rp + 2;
            end
        endcase
        e.res = r;
        if (!(opx == 0 || opx == 8 || opx == 9)) begin
            e.n = ((r >> (w - 1)) & 1) != 0;
            e.z = (r == 0);
        end
        return e;
    endfunction

    task automatic scramble();
        op = 4'($urandom); size = 2'($urandom); rpt = 4'($urandom);
        src = AW'($urandom); dst = AW'($urandom);
        {Cin, Vin, Nin, Zin} = 4'($urandom);
    endtask

    task automatic do_op(input string tag, input int opx, input int sz, input int rp,
                         input logic [AW-1:0] s_v, input logic [AW-1:0] d_v,
                         input logic [3:0] fl, input bit poke);
        exp_t e;
        int   k;
        bit   seen;
        e = model(opx, sz, rp, longint'(s_v), longint'(d_v), fl);
        @(negedge MCLK);
        op = 4'(opx); size = 2'(sz); rpt = 4'(rp); src = s_v; dst = d_v;
        {Cin, Vin, Nin, Zin} = fl;
        start = 1'b1;
        @(negedge MCLK);
        seen = 0;
        for (k = 0; k < 40; k++) begin
            if (k > 0) @(negedge MCLK);
            if (k == 0) check({tag, "_busy"}, busy, 1'b1);
            if (done) begin seen = 1; break; end
            start = poke;
            scramble();
        end
        if (!seen) check({tag, "_timeout"}, 1'b0, 1'b1);
        check({tag, "_lat"}, k + 1, e.lat);
        check({tag, "_res"}, result, e.res[AW-1:0]);
        check({tag, "_flags"}, {Cout, Vout, Nout, Zout}, {e.c, e.v, e.n, e.z});
        start = poke;
        scramble();
        @(negedge MCLK);
        start = 1'b0;
        check({tag, "_idle"}, {busy, done}, 2'b00);
        check({tag, "_hold"}, result, e.res[AW-1:0]);
    endtask

    initial begin
        int  sawdone;
        reset_n = 1'b0;
        start = 1'b0;
        scramble();
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        check("rst_ctl", {busy, done}, 2'b00);
        check("rst_res", result, 20'h0);
        check("rst_flags", {Cout, Vout, Nout, Zout}, 4'b0000);
        reset_n = 1'b1;

        do_op("add_w", 1, 1, 0, 20'h00001, 20'h07FFF, 4'b0000, 1'b0);
        check("add_w_lit", {result, Cout, Vout, Nout, Zout}, {20'h08000, 4'b0110});
        do_op("add_a", 1, 2, 0, 20'h00001, 20'hFFFFF, 4'b0000, 1'b0);
        check("add_a_lit", {result, Cout, Vout, Nout, Zout}, {20'h00000, 4'b1001});
        do_op("add_b", 1, 0, 0, 20'h00001, 20'hFFFFF, 4'b0000, 1'b0);
        check("add_b_lit", {result, Cout, Zout}, {20'h00000, 2'b11});
        do_op("subc_w", 4, 1, 0, 20'h00005, 20'h00005, 4'b0000, 1'b0);
        check("subc_w_lit", {result, Cout, Nout}, {20'h0FFFF, 2'b01});
        do_op("dadd_w", 6, 1, 0, 20'h00001, 20'h00999, 4'b0000, 1'b0);
        check("dadd_w_lit", {result, Cout}, {20'h01000, 1'b0});
        do_op("dadd_b", 6, 0, 0, 20'h00001, 20'h00099, 4'b0000, 1'b0);
        check("dadd_b_lit", {result, Cout, Zout}, {20'h00000, 2'b11});
        do_op("rrax_a", 13, 2, 3, 20'h00000, 20'h80001, 4'b0000, 1'b0);
        check("rrax_a_lit", {result, Cout, Nout}, {20'hF8000, 2'b01});
        do_op("rrux_w", 15, 1, 0, 20'h00000, 20'h08001, 4'b0000, 1'b0);
        check("rrux_w_lit", {result, Cout}, {20'h04000, 1'b1});
        do_op("busy_poke", 3, 1, 0, 20'h01234, 20'h05678, 4'b0000, 1'b1);
        do_op("illegal", 1, 3, 0, 20'h11111, 20'h22222, 4'b1111, 1'b0);
        check("illegal_lit", result, 20'h0DEAD);

        // abort a DADD.A in its third execute cycle
        @(negedge MCLK);
        op = 4'h6; size = 2'b10; src = 20'h12345; dst = 20'h54321; Cin = 1'b0; start = 1'b1;
        @(negedge MCLK);
        start = 1'b0;
        repeat (2) @(negedge MCLK);
        reset_n = 1'b0;
        @(posedge MCLK);
        #1;
        check("midrst_ctl", {busy, done}, 2'b00);
        check("midrst_out", {result, Cout, Vout, Nout, Zout}, 24'h0);
        @(negedge MCLK);
        reset_n = 1'b1;
        sawdone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge MCLK);
            if (done) sawdone++;
        end
        check("midrst_nodone", sawdone, 0);

        for (int i = 0; i < 400; i++) begin
            int sz;
            sz = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
            do_op("rnd", $urandom_range(0, 15), sz, $urandom_range(0, 15),
                  AW'($urandom), AW'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
